program_loader: RTL and testbench

Host-side feeder for the CPU's instruction-load port. Accepts a program as a byte stream (valid/ready), assembles big-endian 32-bit words into an internal buffer, then drives the CPU's `Reset`, `LoadInstructions` and `Instruction` inputs. The CPU's load address counter advances every cycle and is not gated, so the loader writes the whole program as one gap-free burst starting at address 0. Afterwards it resets the CPU pipeline and releases it to run.

---
 rtl/program_loader.sv | 165 ++++++++++++++++
 tb/tb_program_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Collects a big-endian byte stream into a word buffer, then burst-loads it into the CPU (PREP, N BURST cycles, FLUSH, DONE).
// ByteReady depends on state only; define PROGRAM_LOADER_CHECKSUM_EN to treat the final byte as an XOR checksum.
module program_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    input  logic        ByteLast,
    output logic        ByteReady,
    output logic        CpuReset,
    output logic        LoadInstructions,
    output logic [31:0] Instruction,
    output logic        Done,
    output logic        Error
);
    typedef enum logic [2:0] {
        S_COLLECT, S_PREP, S_BURST, S_FLUSH, S_DONE, S_ERROR
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t      state_q, state_d;
    logic [AW:0] n_q, n_d;
    logic [AW:0] i_q, i_d;
    logic [1:0]  pos_q, pos_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        load_q, load_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] instr_q, instr_d;
    logic        wr_en;
    logic [31:0] buf_q [DEPTH];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        pos_d       = pos_q;
        cpu_reset_d = cpu_reset_q;
        load_d      = load_q;
        done_d      = done_q;
        error_d     = error_q;
        instr_d     = instr_q;
        wr_en       = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_COLLECT: begin
                if (ByteValid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (ByteLast) begin
                        // Checksum byte is never stored; it only closes a partial word.
                        if ((n_q == '0 && pos_q == 2'd0) || ByteIn != sum_q) begin
                            state_d = S_ERROR;
                            error_d = 1'b1;
                        end else begin
                            state_d = S_PREP;
                            if (pos_q != 2'd0) n_d = n_q + ONE;
                        end
                    end else if (pos_q == 2'd0 && n_q == FULL) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        sum_d = sum_q ^ ByteIn;
                        pos_d = pos_q + 2'd1;
                        if (pos_q == 2'd3) n_d = n_q + ONE;
                    end
`else
                    if (pos_q == 2'd0 && n_q == FULL) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        pos_d = pos_q + 2'd1;
                        if (pos_q == 2'd3 || ByteLast) n_d = n_q + ONE;
                        if (ByteLast) state_d = S_PREP;
                    end
`endif
                end
            end
            S_PREP: begin
                state_d     = S_BURST;
                cpu_reset_d = 1'b0;
                load_d      = 1'b1;
                instr_d     = buf_q[0];
                i_d         = ONE;
            end
            S_BURST: begin
                if (i_q == n_q) begin
                    state_d     = S_FLUSH;
                    cpu_reset_d = 1'b1;
                    load_d      = 1'b0;
                    instr_d     = '0;
                end else begin
                    instr_d = buf_q[i_q[AW-1:0]];
                    i_d     = i_q + ONE;
                end
            end
            S_FLUSH: begin
                state_d     = S_DONE;
                cpu_reset_d = 1'b0;
                done_d      = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_COLLECT;
            n_q         <= '0;
            i_q         <= '0;
            pos_q       <= '0;
            cpu_reset_q <= 1'b1;
            load_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            instr_q     <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            i_q         <= i_d;
            pos_q       <= pos_d;
            cpu_reset_q <= cpu_reset_d;
            load_q      <= load_d;
            done_q      <= done_d;
            error_q     <= error_d;
            instr_q     <= instr_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // First byte of a word overwrites all of it, so partial words read back zero-padded.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (pos_q)
                2'd0:    buf_q[n_q[AW-1:0]]         <= {ByteIn, 24'h0};
                2'd1:    buf_q[n_q[AW-1:0]][23:16]  <= ByteIn;
                2'd2:    buf_q[n_q[AW-1:0]][15:8]   <= ByteIn;
                default: buf_q[n_q[AW-1:0]][7:0]    <= ByteIn;
            endcase
        end
    end

    assign ByteReady        = (state_q == S_COLLECT);
    assign CpuReset         = cpu_reset_q;
    assign LoadInstructions = load_q;
    assign Instruction      = instr_q;
    assign Done             = done_q;
    assign Error            = error_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed table, hand sequences (overflow, full buffer, reset mid-burst), random streams vs. a word-level model.
module tb_program_loader;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  ByteIn = '0;
    logic        ByteValid = 1'b0;
    logic        ByteLast = 1'b0;
    logic        ByteReady, CpuReset, LoadInstructions, Done, Error;
    logic [31:0] Instruction;

    program_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .Reset(Reset), .ByteIn(ByteIn), .ByteValid(ByteValid),
        .ByteLast(ByteLast), .ByteReady(ByteReady), .CpuReset(CpuReset),
        .LoadInstructions(LoadInstructions), .Instruction(Instruction),
        .Done(Done), .Error(Error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  stream[$];
    logic [31:0] exp_words[$];
    int          exp_err_idx;

    typedef struct {
        int          len;
        logic [63:0] bytes;
        int          nw;
        logic [63:0] words;
        int          err_idx;
    } vec_t;

    task automatic chk1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, ".ready"}, ByteReady, 1'b1);
        chk1({tag, ".cpurst"}, CpuReset, 1'b1);
        chk1({tag, ".load"}, LoadInstructions, 1'b0);
        chk32({tag, ".instr"}, Instruction, 32'h0);
        chk1({tag, ".done"}, Done, 1'b0);
        chk1({tag, ".error"}, Error, 1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        ByteValid = 1'b0;
        ByteLast = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        Reset = 1'b0;
        @(negedge clk);
    endtask

    // Appends the XOR checksum when the build expects one.
    task automatic finish_stream();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        logic [7:0] x = '0;
        foreach (stream[k]) x ^= stream[k];
        stream.push_back(x);
`endif
    endtask

    // Reference model: words are groups of four data bytes, big-endian, zero-padded.
    task automatic compute_expect();
        int ndata;
        exp_words.delete();
        exp_err_idx = -1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ndata = stream.size() - 1;
`else
        ndata = stream.size();
`endif
        if (ndata > 4 * DEPTH) begin
            exp_err_idx = 4 * DEPTH;
            return;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x = '0;
            for (int k = 0; k < ndata; k++) x ^= stream[k];
            if (ndata == 0 || x != stream[ndata]) begin
                exp_err_idx = ndata;
                return;
            end
        end
`endif
        for (int w = 0; w * 4 < ndata; w++) begin
            logic [31:0] word = '0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < ndata) word |= 32'(stream[4 * w + b]) << (24 - 8 * b);
            exp_words.push_back(word);
        end
    endtask

    // Drives the stream with random gaps and checks the whole load sequence;
    // abort_at >= 0 asserts Reset during that (1-based) burst cycle.
    task automatic run_stream(input int gap_max, input int abort_at);
        for (int j = 0; j < stream.size(); j++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                ByteValid = 1'b0;
                ByteLast = 1'($urandom);
                ByteIn = 8'($urandom);
                @(negedge clk);
            end
            ByteValid = 1'b1;
            ByteIn = stream[j];
            ByteLast = (j == stream.size() - 1);
            if (exp_err_idx >= 0 && j > exp_err_idx) begin
                chk1("refused", ByteReady, 1'b0);
                break;
            end
            chk1($sformatf("ready[%0d]", j), ByteReady, 1'b1);
            @(negedge clk);
        end
        ByteValid = 1'b0;
        ByteLast = 1'b0;

        if (exp_err_idx >= 0) begin
            repeat (4) begin
                chk1("err.error", Error, 1'b1);
                chk1("err.cpurst", CpuReset, 1'b1);
                chk1("err.load", LoadInstructions, 1'b0);
                chk1("err.ready", ByteReady, 1'b0);
                chk1("err.done", Done, 1'b0);
                ByteValid = 1'b1;
                @(negedge clk);
                ByteValid = 1'b0;
            end
            return;
        end

        chk1("prep.cpurst", CpuReset, 1'b1);
        chk1("prep.load", LoadInstructions, 1'b0);
        chk1("prep.ready", ByteReady, 1'b0);
        chk32("prep.instr", Instruction, 32'h0);
        @(negedge clk);
        foreach (exp_words[k]) begin
            chk1($sformatf("burst[%0d].load", k), LoadInstructions, 1'b1);
            chk1($sformatf("burst[%0d].cpurst", k), CpuReset, 1'b0);
            chk32($sformatf("burst[%0d].instr", k), Instruction, exp_words[k]);
            if (k + 1 == abort_at) begin
                Reset = 1'b1;
                #1;
                check_reset_values("midreset");
                @(negedge clk);
                Reset = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk1("flush.cpurst", CpuReset, 1'b1);
        chk1("flush.load", LoadInstructions, 1'b0);
        chk32("flush.instr", Instruction, 32'h0);
        chk1("flush.done", Done, 1'b0);
        @(negedge clk);
        repeat (3) begin
            chk1("done.done", Done, 1'b1);
            chk1("done.cpurst", CpuReset, 1'b0);
            chk1("done.load", LoadInstructions, 1'b0);
            chk1("done.ready", ByteReady, 1'b0);
            chk1("done.error", Error, 1'b0);
            ByteValid = 1'b1;
            @(negedge clk);
            ByteValid = 1'b0;
        end
    endtask

    initial begin
        vec_t vecs[4];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        vecs[0] = '{len: 5, bytes: 64'hAA550FF0_00000000, nw: 1, words: 64'hAA550FF0_00000000, err_idx: -1};
        vecs[1] = '{len: 5, bytes: 64'hAA550FF0_01000000, nw: 0, words: 64'h0, err_idx: 4};
        vecs[2] = '{len: 1, bytes: 64'h5A000000_00000000, nw: 0, words: 64'h0, err_idx: 0};
        vecs[3] = '{len: 3, bytes: 64'h11223300_00000000, nw: 1, words: 64'h11220000_00000000, err_idx: -1};
`else
        vecs[0] = '{len: 4, bytes: 64'h20080005_00000000, nw: 1, words: 64'h20080005_00000000, err_idx: -1};
        vecs[1] = '{len: 6, bytes: 64'h11121314_15160000, nw: 2, words: 64'h11121314_15160000, err_idx: -1};
        vecs[2] = '{len: 1, bytes: 64'hAB000000_00000000, nw: 1, words: 64'hAB000000_00000000, err_idx: -1};
        vecs[3] = '{len: 8, bytes: 64'h01020304_05060708, nw: 2, words: 64'h01020304_05060708, err_idx: -1};
`endif
        @(negedge clk);
        do_reset();

        foreach (vecs[t]) begin
            logic [63:0] tb_bytes = vecs[t].bytes;
            logic [63:0] tb_words = vecs[t].words;
            stream.delete();
            exp_words.delete();
            for (int k = 0; k < vecs[t].len; k++) stream.push_back(tb_bytes[63 - 8 * k -: 8]);
            for (int w = 0; w < vecs[t].nw; w++) exp_words.push_back(tb_words[63 - 32 * w -: 32]);
            exp_err_idx = vecs[t].err_idx;
            run_stream(2 * t, -1);
            do_reset();
        end

        // Buffer exactly full, then one byte more than fits.
        for (int extra = 0; extra < 2; extra++) begin
            stream.delete();
            for (int k = 0; k < 4 * DEPTH + extra; k++) stream.push_back(8'(k * 7 + 1));
            finish_stream();
            compute_expect();
            run_stream(1, -1);
            do_reset();
        end

        // Reset during the third burst cycle, then a fresh one-word load.
        stream.delete();
        for (int k = 0; k < 4 * DEPTH; k++) stream.push_back(8'(8'hC0 + k));
        finish_stream();
        compute_expect();
        run_stream(0, 3);
        stream.delete();
        stream.push_back(8'hDE); stream.push_back(8'hAD);
        stream.push_back(8'hBE); stream.push_back(8'hEF);
        finish_stream();
        compute_expect();
        run_stream(0, -1);
        do_reset();

        for (int r = 0; r < 25; r++) begin
            int len;
            stream.delete();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            len = $urandom_range(4 * DEPTH + 3, 0);
`else
            len = $urandom_range(4 * DEPTH + 3, 1);
`endif
            for (int k = 0; k < len; k++) stream.push_back(8'($urandom));
            finish_stream();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if ($urandom_range(3, 0) == 0)
                stream[stream.size() - 1] = stream[stream.size() - 1] ^ 8'h5A;
`endif
            compute_expect();
            run_stream(3, -1);
            do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
